// File: rtl/mem_pkg.sv
// Shared definitions for the data memory: RISC-V load/store size encodings
// and the clear/ready state encoding.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/load_ext.sv
// Combinational load formatter: picks the addressed byte/half from a 32-bit
// little-endian word and sign- or zero-extends it according to Funct3.
module load_ext
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = word >> {byte_sel, 3'b000};
    b       = shifted[7:0];
    h       = byte_sel[1] ? word[31:16] : word[15:0];
    data    = '0;
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_W:    data = word;
      F3_BU:   data = {24'd0, b};
      F3_HU:   data = {16'd0, h};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed data memory with zero-latency loads, lane-masked stores,
// combinational fault flags and a post-reset clear sweep of every word.
module data_mem
  import mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Addr,
  input  logic [WIDTH-1:0] DataW,
  input  logic             MemRW,
  input  logic [2:0]       Funct3,
  output logic [WIDTH-1:0] DataR,
  output logic             Busy,
  output logic             MisAlign,
  output logic             AccessErr
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  mem_state_e       state, state_nx;
  logic [AW-1:0]    ptr, ptr_nx;
  logic             ready;
  logic [AW-1:0]    widx;
  logic             out_of_range, f3_illegal, store_size_err;
  logic             is_half, is_word, mis_raw, fault, we;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata, rd_word, ext_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      CLEAR: begin
        ptr_nx = ptr + 1'b1;
        if (ptr == AW'(DEPTH - 1)) state_nx = READY;
      end
      READY:   state_nx = READY;
      default: state_nx = CLEAR;
    endcase
  end

  assign ready = (state == READY);
  assign Busy  = !ready;
  assign widx  = Addr[AW+1:2];

  // Any upper address bit set means past the end; no aliasing onto low words.
  assign out_of_range   = |Addr[WIDTH-1:AW+2];
  assign f3_illegal     = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
  assign store_size_err = MemRW && ((Funct3 == F3_BU) || (Funct3 == F3_HU));
  assign is_half        = (Funct3 == F3_H) || (Funct3 == F3_HU);
  assign is_word        = (Funct3 == F3_W);
  assign mis_raw        = (is_half && Addr[0]) || (is_word && (Addr[1:0] != 2'b00));

  assign MisAlign  = ready && mis_raw;
  assign AccessErr = ready && (out_of_range || f3_illegal || store_size_err);
  assign fault     = MisAlign || AccessErr;
  assign we        = ready && MemRW && !fault;

  // Store data is replicated across lanes so the byte enables alone select it.
  always_comb begin
    be    = 4'b0000;
    wdata = DataW;
    case (Funct3)
      F3_B: begin
        be    = 4'b0001 << Addr[1:0];
        wdata = {4{DataW[7:0]}};
      end
      F3_H: begin
        be    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{DataW[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!ready) begin
        mem[ptr] <= '0;
      end else if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rd_word = mem[widx];

  load_ext u_load_ext (
    .funct3   (Funct3),
    .byte_sel (Addr[1:0]),
    .word     (rd_word),
    .data     (ext_data)
  );

  assign DataR = (ready && !MemRW && !fault) ? ext_data : '0;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: clear timing, load formatting, lane stores,
// fault flags, same-cycle store/load and random traffic against a byte model.
module tb_data_mem;
  import mem_pkg::*;

  localparam int W = 32;
  localparam int MEM_BYTES = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] Addr = '0;
  logic [W-1:0] DataW = '0;
  logic         MemRW = 1'b0;
  logic [2:0]   Funct3 = F3_W;
  logic [W-1:0] DataR;
  logic         Busy, MisAlign, AccessErr;

  logic [W-1:0] exp_q[$];
  logic [7:0]   mdl [MEM_BYTES];
  int           n_chk = 0;
  int           n_err = 0;

  data_mem #(.WIDTH(32), .DEPTH(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .Addr      (Addr),
    .DataW     (DataW),
    .MemRW     (MemRW),
    .Funct3    (Funct3),
    .DataR     (DataR),
    .Busy      (Busy),
    .MisAlign  (MisAlign),
    .AccessErr (AccessErr)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // reference model helpers
  function automatic logic [1:0] exp_flags(input logic [2:0] f3, input logic [W-1:0] a,
                                           input logic st);
    logic mis, err;
    mis = (((f3 == F3_H) || (f3 == F3_HU)) && a[0]) || ((f3 == F3_W) && (a[1:0] != 2'b00));
    err = (a >= MEM_BYTES) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
          (st && ((f3 == F3_BU) || (f3 == F3_HU)));
    return {mis, err};
  endfunction

  function automatic logic [W-1:0] exp_load(input logic [2:0] f3, input logic [W-1:0] a);
    int base;
    logic [7:0]  b;
    logic [15:0] h;
    if (exp_flags(f3, a, 1'b0) != 2'b00) return '0;
    base = int'(a);
    b = mdl[base];
    h = {mdl[base - (base % 2) + 1], mdl[base - (base % 2)]};
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'd0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'd0, h};
      default: return {mdl[base + 3], mdl[base + 2], mdl[base + 1], mdl[base]};
    endcase
  endfunction

  // driver tasks (inputs change on the falling edge)
  task automatic do_store(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] d);
    int base;
    MemRW = 1'b1; Funct3 = f3; Addr = a; DataW = d;
    #1;
    chk("store_dataR_zero", DataR, '0);
    chk("store_flags", {30'd0, MisAlign, AccessErr}, {30'd0, exp_flags(f3, a, 1'b1)});
    if (exp_flags(f3, a, 1'b1) == 2'b00) begin
      base = int'(a);
      case (f3)
        F3_B: mdl[base] = d[7:0];
        F3_H: begin mdl[base] = d[7:0]; mdl[base + 1] = d[15:8]; end
        default: for (int i = 0; i < 4; i++) mdl[base + i] = d[8*i +: 8];
      endcase
    end
    @(negedge clk);
    MemRW = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                         input logic [W-1:0] exp);
    MemRW = 1'b0; Funct3 = f3; Addr = a;
    exp_q.push_back(exp);
    #1;
    chk(tag, DataR, exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // counts sampled cycles with Busy high, starting with the current one
  task automatic count_busy(output int n);
    n = 0;
    while (Busy && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : main
    int n;
    logic [2:0] f3_tab [5];
    logic [2:0] f3;
    logic [W-1:0] a, d;
    f3_tab[0] = F3_B; f3_tab[1] = F3_H; f3_tab[2] = F3_W;
    f3_tab[3] = F3_BU; f3_tab[4] = F3_HU;
    for (int i = 0; i < MEM_BYTES; i++) mdl[i] = 8'h00;

    // reset and clear timing
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, Busy}, 32'd1);
    chk("rst_dataR", DataR, '0);
    chk("rst_misalign", {31'd0, MisAlign}, 32'd0);
    chk("rst_accesserr", {31'd0, AccessErr}, 32'd0);
    count_busy(n);
    chk("clear_cycles", n, 32'd256);
    @(negedge clk);
    for (int i = 0; i < 256; i++) do_load("clear_zero", F3_W, i * 4, 32'h0);

    // load formatting
    do_store(F3_W, 32'h10, 32'h8899AABB);
    do_load("lb_13", F3_B, 32'h13, 32'hFFFFFF88);
    do_load("lbu_13", F3_BU, 32'h13, 32'h00000088);
    do_load("lh_10", F3_H, 32'h10, 32'hFFFFAABB);
    do_load("lhu_12", F3_HU, 32'h12, 32'h00008899);
    do_load("lb_10", F3_B, 32'h10, 32'hFFFFFFBB);
    do_load("lh_12", F3_H, 32'h12, 32'hFFFF8899);

    // byte and half lane stores
    do_store(F3_W, 32'h10, 32'h11223344);
    do_store(F3_B, 32'h11, 32'h000000CC);
    do_load("sb_lane", F3_W, 32'h10, 32'h1122CC44);
    do_store(F3_H, 32'h12, 32'h0000BEEF);
    do_load("sh_lane", F3_W, 32'h10, 32'hBEEFCC44);

    // faults
    do_store(F3_W, 32'h4, 32'hA5A5A5A5);
    do_store(F3_W, 32'h6, 32'hFFFFFFFF);
    do_load("misaligned_sw_w1", F3_W, 32'h4, 32'hA5A5A5A5);
    do_load("misaligned_sw_w2", F3_W, 32'h8, 32'h00000000);
    do_store(F3_H, 32'h5, 32'h00001234);
    do_load("misaligned_sh", F3_W, 32'h4, 32'hA5A5A5A5);
    do_store(F3_BU, 32'h4, 32'h00000000);
    do_load("sbu_suppressed", F3_W, 32'h4, 32'hA5A5A5A5);
    MemRW = 1'b0; Funct3 = F3_W; Addr = 32'h400;
    #1;
    chk("lw_400_err", {30'd0, MisAlign, AccessErr}, 32'd1);
    chk("lw_400_data", DataR, '0);
    Funct3 = 3'b011; Addr = 32'h4;
    #1;
    chk("f3_011_err", {30'd0, MisAlign, AccessErr}, 32'd1);
    chk("f3_011_data", DataR, '0);
    Funct3 = F3_H; Addr = 32'h5;
    #1;
    chk("lh_mis_flags", {30'd0, MisAlign, AccessErr}, 32'd2);
    Funct3 = 3'b111; Addr = 32'h7;
    #1;
    chk("both_flags", {30'd0, MisAlign, AccessErr}, 32'd1);
    Funct3 = F3_W; Addr = 32'h403;
    #1;
    chk("both_flags_w", {30'd0, MisAlign, AccessErr}, 32'd3);
    @(negedge clk);
    do_store(F3_W, 32'h3FC, 32'hCAFEF00D);
    do_load("last_word", F3_W, 32'h3FC, 32'hCAFEF00D);
    do_load("flags_clear_next", F3_W, 32'h4, 32'hA5A5A5A5);

    // store with same-cycle load
    do_store(F3_W, 32'h20, 32'hDEADBEEF);
    do_load("lw_after_sw", F3_W, 32'h20, 32'hDEADBEEF);

    // random traffic against the byte model, including misaligned and out-of-range
    for (int i = 0; i < 150; i++) begin
      f3 = f3_tab[$urandom_range(0, 4)];
      a  = $urandom_range(0, 1100);
      d  = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        do_store(f3, a, d);
      end else begin
        MemRW = 1'b0; Funct3 = f3; Addr = a;
        #1;
        chk("rnd_flags", {30'd0, MisAlign, AccessErr}, {30'd0, exp_flags(f3, a, 1'b0)});
        @(negedge clk);
        do_load("rnd_load", f3, a, exp_load(f3, a));
      end
    end

    // reset mid-clear restarts the sweep; stores while busy are dropped
    pulse_reset();
    repeat (100) @(negedge clk);
    chk("mid_clear_busy", {31'd0, Busy}, 32'd1);
    pulse_reset();
    MemRW = 1'b1; Funct3 = F3_W; Addr = 32'h30; DataW = 32'h12345678;
    #1;
    chk("busy_store_flags", {30'd0, MisAlign, AccessErr}, 32'd0);
    chk("busy_store_data", DataR, '0);
    count_busy(n);
    MemRW = 1'b0;
    chk("restart_cycles", n, 32'd256);
    @(negedge clk);
    do_load("busy_sw_dropped", F3_W, 32'h30, 32'h0);
    do_load("recleared_20", F3_W, 32'h20, 32'h0);
    do_load("recleared_3fc", F3_W, 32'h3FC, 32'h0);

    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data and address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256, giving the number of WIDTH-bit words, a power of two (1 KB at defaults).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port Addr, input, WIDTH bits: byte address, driven by the ALU result ALUOut.
REQ-006 The block SHALL have port DataW, input, WIDTH bits: store data (rs2).
REQ-007 The block SHALL have port MemRW, input, 1 bit: 1 = store, 0 = load/idle.
REQ-008 The block SHALL have port Funct3, input, 3 bits: access size/sign, RISC-V encoding (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 The block SHALL have port DataR, output, WIDTH bits: formatted load data.
REQ-010 The block SHALL have port Busy, output, 1 bit: high while the post-reset clear is in progress.
REQ-011 The block SHALL have port MisAlign, output, 1 bit: the current access is misaligned.
REQ-012 The block SHALL have port AccessErr, output, 1 bit: the current access is out of range or has an illegal Funct3.

Function
REQ-013 Storage SHALL be DEPTH little-endian words, word index Addr[log2(DEPTH)+1:2].
REQ-014 The FSM SHALL have states CLEAR and READY; CLEAR writes 0 to word ptr each cycle and increments ptr; at ptr = DEPTH-1 it writes, then goes to READY.
REQ-015 In CLEAR: Busy = 1, DataR = 0, MisAlign = 0, AccessErr = 0, stores ignored; the clear takes exactly DEPTH cycles.
REQ-016 In READY, loads SHALL be combinational (zero latency): DataR is valid in the same cycle as Addr/Funct3.
REQ-017 Load formatting SHALL be: B/H sign-extend, BU/HU zero-extend; the selected byte is Addr[1:0] and the selected half is Addr[1].
REQ-018 Stores SHALL write on the rising edge when MemRW = 1, READY, and no fault; SB writes one byte lane, SH two lanes, SW all four; other lanes are unchanged.
REQ-019 When MemRW = 1, DataR SHALL be 0; a load of a word written in the same cycle shows the old value until the edge.
REQ-020 MisAlign SHALL be 1 for H/HU/SH with Addr[0] = 1, and for W/SW with Addr[1:0] != 0.
REQ-021 AccessErr SHALL be 1 when Addr >= 4*DEPTH, when Funct3 is in {011, 110, 111}, or for a store with Funct3 100/101.
REQ-022 On any fault: the store is suppressed, DataR = 0, and the flags are combinational for the current cycle only (not sticky); if both flag conditions hold, both assert.
REQ-023 Addr arithmetic SHALL be unsigned; there is no wrap-around; addresses beyond range fault rather than alias.

Reset
REQ-024 With rst = 1 at a clock edge: state <= CLEAR, ptr <= 0; memory is not written in that cycle.
REQ-025 Immediately after reset: Busy = 1, DataR = 0, MisAlign = 0, AccessErr = 0.
REQ-026 rst asserted mid-CLEAR SHALL restart the clear at ptr = 0; rst in READY SHALL discard any store presented in that cycle.

Structure
REQ-027 A shared package mem_pkg SHALL hold the Funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state encoding (CLEAR, READY).
REQ-028 The design SHALL have one combinational sub-module, load_ext (Funct3, Addr[1:0], word -> DataR), reusable by a later cache.
REQ-029 The memory array, FSM, pointer, byte-enable generation and fault logic SHALL reside in data_mem.

Verification
REQ-030 rst for 1 cycle then release -> Busy high for exactly 256 cycles, then low; every word reads 0.
REQ-031 SW Addr=0x10 DataW=0x8899AABB; then LB 0x13 -> 0xFFFFFF88, LBU 0x13 -> 0x00000088, LH 0x10 -> 0xFFFFAABB, LHU 0x12 -> 0x00008899.
REQ-032 SB Addr=0x11 DataW=0x000000CC over word 0x11223344 -> LW 0x10 = 0x1122CC44.
REQ-033 SW Addr=0x6 -> MisAlign=1, memory unchanged; LW 0x400 -> AccessErr=1, DataR=0; Funct3=011 -> AccessErr=1.
REQ-034 rst at clear cycle 100 -> the clear restarts and Busy stays high 256 more cycles; an SW issued while Busy -> no write.
REQ-035 SW 0x20 0xDEADBEEF with LW 0x20 in the same cycle -> DataR = 0 in that cycle (MemRW=1); the next-cycle load -> 0xDEADBEEF.
